// File: rtl/z_pkg.sv
// Shared constants and state encoding for the sequential multiplier and its adder.
package z_pkg;

   localparam int unsigned N_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage : z_pkg

// File: rtl/z_n_rca.sv
// Combinational n-bit ripple-carry adder with carry-in and carry-out.
module z_n_rca
   import z_pkg::*;
#(
   parameter int unsigned n = N_DEF
) (
   input  logic [n-1:0] a,
   input  logic [n-1:0] b,
   input  logic         c_in,
   output logic [n-1:0] sum,
   output logic         c_out
);

   logic [n:0] carry;

   always_comb begin
      sum      = '0;
      carry    = '0;
      carry[0] = c_in;
      for (int i = 0; i < int'(n); i++) begin
         sum[i]     = a[i] ^ b[i] ^ carry[i];
         carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
      end
      c_out = carry[n];
   end

endmodule : z_n_rca

// File: rtl/z_seq_mult.sv
// Unsigned n x n shift-and-add multiplier, one partial product per clock,
// with a start/ready/done handshake. The adder carry-out lands in the product MSB.
module z_seq_mult
   import z_pkg::*;
#(
   parameter int unsigned n = N_DEF
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [n-1:0]   a,
   input  logic [n-1:0]   b,
   output logic           ready,
   output logic           busy,
   output logic           done,
   output logic [2*n-1:0] product
);

   localparam int unsigned PW = 2 * n;
   localparam int unsigned CW = $clog2(n);

   state_e          state_q;
   logic [n-1:0]    mcand_q;
   logic [PW-1:0]   product_q;
   logic [PW-1:0]   product_d;
   logic [CW-1:0]   count_q;
   logic            ready_q;
   logic            busy_q;
   logic            done_q;

   logic [n-1:0]    sum;
   logic            c_out;

   z_n_rca #(.n(n)) u_rca (
      .a     (product_q[PW-1:n]),
      .b     (mcand_q),
      .c_in  (1'b0),
      .sum   (sum),
      .c_out (c_out)
   );

   // One shift-and-add step: add multiplicand to the upper half when the LSB is set.
   always_comb begin
      product_d = {1'b0, product_q[PW-1:1]};
      if (product_q[0]) begin
         product_d = {c_out, sum, product_q[n-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         mcand_q   <= '0;
         product_q <= '0;
         count_q   <= '0;
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start && ready_q) begin
                  mcand_q   <= a;
                  product_q <= {{n{1'b0}}, b};
                  count_q   <= '0;
                  state_q   <= ST_RUN;
                  ready_q   <= 1'b0;
                  busy_q    <= 1'b1;
               end
            end
            ST_RUN: begin
               product_q <= product_d;
               count_q   <= count_q + CW'(1);
               if (count_q == CW'(n - 1)) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               done_q  <= 1'b0;
               ready_q <= 1'b1;
            end
            // Unreachable encoding recovers to idle.
            default: begin
               state_q <= ST_IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign ready   = ready_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign product = product_q;

endmodule : z_seq_mult

// File: tb/tb_z_seq_mult.sv
// Directed bench for z_seq_mult (n=4): handshake timing, operand latching,
// abort by reset, and an exhaustive product sweep.
module tb_z_seq_mult;

   localparam int unsigned N = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic           start;
   logic [N-1:0]   a;
   logic [N-1:0]   b;
   logic           ready;
   logic           busy;
   logic           done;
   logic [2*N-1:0] product;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   z_seq_mult #(.n(N)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .a       (a),
      .b       (b),
      .ready   (ready),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   // Present operands with start for exactly one edge.
   task automatic start_op(input logic [N-1:0] av, input logic [N-1:0] bv);
      a = av;
      b = bv;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Count edges after acceptance until done is seen (bounded).
   task automatic wait_done(output int cyc);
      cyc = 0;
      do begin
         @(posedge clk);
         #1;
         cyc++;
      end while (!done && cyc < 20);
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if ({ready, busy, done} !== 3'b100) begin
         miscompares++;
         $display("FAIL reset_flags: got rdy/busy/done=%b expected 100", {ready, busy, done});
      end
      vectors++;
      if (product !== 8'h00) begin
         miscompares++;
         $display("FAIL reset_product: got %h expected 00", product);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int cyc;
      start_op(4'd8, 4'd15);
      vectors++;
      if ({ready, busy} !== 2'b01) begin
         miscompares++;
         $display("FAIL t1_run_flags: got rdy/busy=%b expected 01", {ready, busy});
      end
      wait_done(cyc);
      vectors++;
      if (cyc != 4) begin
         miscompares++;
         $display("FAIL t1_latency: got %0d edges expected 4", cyc);
      end
      vectors++;
      if (product !== 8'h78 || ready !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL t1_done: got product=%h rdy=%b busy=%b expected 78 0 0", product, ready, busy);
      end
      @(posedge clk);
      #1;
      vectors++;
      if (done !== 1'b0 || ready !== 1'b1) begin
         miscompares++;
         $display("FAIL t1_idle_return: got done=%b rdy=%b expected 0 1", done, ready);
      end
   endtask

   task automatic test_max();
      int cyc;
      start_op(4'd15, 4'd15);
      wait_done(cyc);
      vectors++;
      if (cyc != 4 || product !== 8'hE1) begin
         miscompares++;
         $display("FAIL t2_max: got edges=%0d product=%h expected 4 e1", cyc, product);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_zero();
      logic [N-1:0] av [2] = '{4'd0, 4'd9};
      logic [N-1:0] bv [2] = '{4'd9, 4'd0};
      int cyc;
      for (int i = 0; i < 2; i++) begin
         start_op(av[i], bv[i]);
         wait_done(cyc);
         vectors++;
         if (cyc != 4 || product !== 8'h00) begin
            miscompares++;
            $display("FAIL t3_zero_%0d: got edges=%0d product=%h expected 4 00", i, cyc, product);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_back_to_back();
      int cyc;
      a = 4'd3; b = 4'd5; start = 1'b1;
      @(posedge clk);
      #1;
      cyc = 0;
      do begin
         a = N'(cyc * 5 + 1);
         b = N'(cyc * 3 + 2);
         @(posedge clk);
         #1;
         cyc++;
      end while (!done && cyc < 20);
      vectors++;
      if (cyc != 4 || product !== 8'h0F) begin
         miscompares++;
         $display("FAIL t4_latched: got edges=%0d product=%h expected 4 0f", cyc, product);
      end
      a = 4'd2; b = 4'd7;
      @(posedge clk);
      #1;
      vectors++;
      if ({ready, busy, done} !== 3'b100 || product !== 8'h0F) begin
         miscompares++;
         $display("FAIL t4_ready_restore: got rdy/busy/done=%b product=%h expected 100 0f",
                  {ready, busy, done}, product);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      vectors++;
      if ({ready, busy} !== 2'b01) begin
         miscompares++;
         $display("FAIL t4_second_accept: got rdy/busy=%b expected 01", {ready, busy});
      end
      wait_done(cyc);
      vectors++;
      if (cyc != 4 || product !== 8'h0E) begin
         miscompares++;
         $display("FAIL t4_second: got edges=%0d product=%h expected 4 0e", cyc, product);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_abort();
      int cyc;
      bit saw_done;
      start_op(4'd6, 4'd7);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      vectors++;
      if ({ready, busy, done} !== 3'b100 || product !== 8'h00) begin
         miscompares++;
         $display("FAIL t5_abort: got rdy/busy/done=%b product=%h expected 100 00",
                  {ready, busy, done}, product);
      end
      saw_done = 1'b0;
      repeat (8) begin
         @(posedge clk);
         #1;
         if (done) saw_done = 1'b1;
      end
      vectors++;
      if (saw_done !== 1'b0 || product !== 8'h00) begin
         miscompares++;
         $display("FAIL t5_no_done: got done_seen=%b product=%h expected 0 00", saw_done, product);
      end
      start_op(4'd6, 4'd7);
      wait_done(cyc);
      vectors++;
      if (cyc != 4 || product !== 8'h2A) begin
         miscompares++;
         $display("FAIL t5_restart: got edges=%0d product=%h expected 4 2a", cyc, product);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_sweep();
      int cyc;
      logic [2*N-1:0] exp_p;
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 16; j++) begin
            exp_p = (2*N)'(i * j);
            start_op(N'(i), N'(j));
            wait_done(cyc);
            vectors++;
            if (cyc != 4 || product !== exp_p) begin
               miscompares++;
               $display("FAIL t6_sweep a=%0d b=%0d: got edges=%0d product=%0d expected 4 %0d",
                        i, j, cyc, product, exp_p);
            end
            @(posedge clk);
            #1;
            vectors++;
            if (done !== 1'b0 || ready !== 1'b1) begin
               miscompares++;
               $display("FAIL t6_done_width a=%0d b=%0d: got done=%b rdy=%b expected 0 1",
                        i, j, done, ready);
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      a = '0;
      b = '0;
      test_reset();
      test_basic();
      test_max();
      test_zero();
      test_back_to_back();
      test_abort();
      test_sweep();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_z_seq_mult
